// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: mnemonic, opcode and func constants shared with the control decoder.
package instr_encoder_pkg;
  localparam logic [4:0] M_ADD   = 5'd0;
  localparam logic [4:0] M_ADDU  = 5'd1;
  localparam logic [4:0] M_SUB   = 5'd2;
  localparam logic [4:0] M_SUBU  = 5'd3;
  localparam logic [4:0] M_AND   = 5'd4;
  localparam logic [4:0] M_OR    = 5'd5;
  localparam logic [4:0] M_XOR   = 5'd6;
  localparam logic [4:0] M_NOR   = 5'd7;
  localparam logic [4:0] M_SLT   = 5'd8;
  localparam logic [4:0] M_SLTU  = 5'd9;
  localparam logic [4:0] M_ADDI  = 5'd10;
  localparam logic [4:0] M_ADDIU = 5'd11;
  localparam logic [4:0] M_ANDI  = 5'd12;
  localparam logic [4:0] M_ORI   = 5'd13;
  localparam logic [4:0] M_SLTI  = 5'd14;
  localparam logic [4:0] M_SLTIU = 5'd15;
  localparam logic [4:0] M_LW    = 5'd16;
  localparam logic [4:0] M_SW    = 5'd17;
  localparam logic [4:0] M_BEQ   = 5'd18;
  localparam logic [4:0] M_BNE   = 5'd19;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;
endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack: combinational mnemonic + fields to {legal, 32-bit MIPS word}.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic        legal,
  output logic [31:0] word
);
  logic       r_type;
  logic [5:0] func;
  logic [5:0] op;
  always_comb begin
    func = 6'h00;
    op = OP_RTYPE;
    case (mnem)
      M_ADD:   func = F_ADD;
      M_ADDU:  func = F_ADDU;
      M_SUB:   func = F_SUB;
      M_SUBU:  func = F_SUBU;
      M_AND:   func = F_AND;
      M_OR:    func = F_OR;
      M_XOR:   func = F_XOR;
      M_NOR:   func = F_NOR;
      M_SLT:   func = F_SLT;
      M_SLTU:  func = F_SLTU;
      M_ADDI:  op = OP_ADDI;
      M_ADDIU: op = OP_ADDIU;
      M_ANDI:  op = OP_ANDI;
      M_ORI:   op = OP_ORI;
      M_SLTI:  op = OP_SLTI;
      M_SLTIU: op = OP_SLTIU;
      M_LW:    op = OP_LW;
      M_SW:    op = OP_SW;
      M_BEQ:   op = OP_BEQ;
      M_BNE:   op = OP_BNE;
      default: ;
    endcase
    r_type = mnem <= M_SLTU;
    legal = mnem <= M_BNE;
    word = r_type ? {OP_RTYPE, rs, rt, rd, 5'b00000, func} : {op, rs, rt, imm};
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: registered valid/ready encoder of symbolic requests into MIPS words,
// tracking the imem write address and the count of emitted words.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       instr_count,
  output logic              err_illegal
);
  logic        legal;
  logic [31:0] word;
  logic        acc;
  logic        hs;
  instr_field_pack u_pack (
    .mnem(in_mnem), .rs(in_rs), .rt(in_rt), .rd(in_rd), .imm(in_imm),
    .legal(legal), .word(word)
  );
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  // out_addr advances on drain, so an idle register already holds the next word's address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
      out_addr <= ADDR_W'(BASE_ADDR);
      instr_count <= 16'h0;
      err_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_addr <= ADDR_W'(BASE_ADDR);
      instr_count <= 16'h0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= acc && !legal;
      out_valid <= acc ? legal : (out_valid && !hs);
      if (acc && legal) out_instr <= word;
      if (hs) out_addr <= out_addr + ADDR_W'(4);
      if (hs && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with a queue scoreboard and a decoupled output monitor.
module tb_instr_encoder;
  typedef struct {
    logic [31:0] instr;
    logic [7:0]  addr;
    bit          b2b;
  } exp_t;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [4:0]  in_mnem = 0, in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic        in_ready, out_valid, err_illegal;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [15:0] instr_count;
  logic        r4 = 1, v4 = 0, z4 = 0, rdy4, ov4, e4;
  logic [31:0] oi4;
  logic [3:0]  oa4;
  logic [15:0] c4;
  exp_t        q[$];
  logic [3:0]  q4[$];
  int          checks = 0, errs = 0, cyc = 0, last_hs = -10, err_pulses = 0;
  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .instr_count(instr_count), .err_illegal(err_illegal)
  );
  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut4 (
    .clk(clk), .reset(r4), .flush(z4), .in_valid(v4), .in_ready(rdy4),
    .in_mnem(5'd0), .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd3), .in_imm(16'h0),
    .out_valid(ov4), .out_ready(1'b1), .out_instr(oi4), .out_addr(oa4),
    .instr_count(c4), .err_illegal(e4)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && err_illegal) err_pulses++;
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_instr, 32'hxxxxxxxx);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_addr", {24'h0, out_addr}, {24'h0, e.addr});
        if (e.b2b) chk("no_bubble", cyc, last_hs + 1);
      end
      last_hs = cyc;
    end
    if (!r4 && ov4) begin
      if (q4.size() == 0) chk("w4_unexpected", {28'h0, oa4}, 32'hxxxxxxxx);
      else chk("w4_addr", {28'h0, oa4}, {28'h0, q4.pop_front()});
    end
  end
  task automatic send(input logic [4:0] m, rs, rt, rd, input logic [15:0] imm,
                      input logic [31:0] w, input logic [7:0] a, input bit legal, input bit b2b);
    in_valid = 1; in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'h1);
    else if (legal) q.push_back('{w, a, b2b});
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_addr", {24'h0, out_addr}, 0);
    chk("rst_count", {16'h0, instr_count}, 0);
    chk("rst_err", 32'(err_illegal), 0);
    reset = 0; r4 = 0;
    q4 = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    v4 = 1;
    repeat (5) @(posedge clk);
    #1 v4 = 0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 8'h00, 1, 0);
    drain();
    chk("count_after_add", {16'h0, instr_count}, 1);
    chk("w4_count", {16'h0, c4}, 5);
    chk("w4_queue_empty", q4.size(), 0);
    send(5'd10, 5'd0, 5'd8, 5'd0, 16'h0005, 32'h20080005, 8'h04, 1, 0);
    send(5'd16, 5'd29, 5'd4, 5'd0, 16'h0010, 32'h8FA40010, 8'h08, 1, 1);
    drain();
    out_ready = 0;
    send(5'd19, 5'd1, 5'd2, 5'd0, 16'hFFFE, 32'h1422FFFE, 8'h0C, 1, 0);
    in_valid = 1; in_mnem = 5'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_instr", out_instr, 32'h1422FFFE);
      chk("stall_addr", {24'h0, out_addr}, 32'h0C);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    drain();
    chk("count_after_bne", {16'h0, instr_count}, 4);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush_addr", {24'h0, out_addr}, 0);
    chk("flush_count", {16'h0, instr_count}, 0);
    err_pulses = 0;
    send(5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 32'h00642822, 8'h00, 1, 0);
    send(5'd25, 5'd1, 5'd1, 5'd1, 16'h1, 32'h0, 8'h00, 0, 0);
    send(5'd2, 5'd6, 5'd7, 5'd8, 16'h0, 32'h00C74022, 8'h04, 1, 0);
    drain();
    chk("illegal_pulses", err_pulses, 1);
    chk("count_after_sub", {16'h0, instr_count}, 2);
    out_ready = 0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 8'h08, 1, 0);
    @(negedge clk);
    chk("pre_reset_valid", 32'(out_valid), 1);
    #2 reset = 1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_instr", out_instr, 0);
    chk("async_addr", {24'h0, out_addr}, 0);
    chk("async_count", {16'h0, instr_count}, 0);
    chk("async_err", 32'(err_illegal), 0);
    q.delete();
    @(posedge clk); #1 reset = 0; out_ready = 1;
    send(5'd13, 5'd1, 5'd2, 5'd0, 16'h1234, 32'h34221234, 8'h00, 1, 0);
    send(5'd12, 5'd1, 5'd2, 5'd0, 16'h1234, 32'h30221234, 8'h04, 1, 1);
    send(5'd6, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221826, 8'h08, 1, 1);
    drain();
    chk("count_pre_flush", {16'h0, instr_count}, 3);
    flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush2_valid", 32'(out_valid), 0);
    chk("flush2_addr", {24'h0, out_addr}, 0);
    chk("flush2_count", {16'h0, instr_count}, 0);
    send(5'd8, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0022182A, 8'h00, 1, 0);
    drain();
    chk("count_after_flush", {16'h0, instr_count}, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
